// File: rtl/instr_pkg.sv
// ISA opcode constants and fetch FSM types for the matrix-multiplier core.
// Shared by the fetch sequencer, the instruction memory and the execute FSM.
package instr_pkg;

    localparam logic [7:0] OP_LDACI  = 8'd0;
    localparam logic [7:0] OP_LDAC   = 8'd1;
    localparam logic [7:0] OP_STAC   = 8'd2;
    localparam logic [7:0] OP_MVACR  = 8'd3;
    localparam logic [7:0] OP_MVRAC  = 8'd4;
    localparam logic [7:0] OP_MVACRI = 8'd5;
    localparam logic [7:0] OP_MVACRJ = 8'd6;
    localparam logic [7:0] OP_MVACRK = 8'd7;
    localparam logic [7:0] OP_MVRIAC = 8'd8;
    localparam logic [7:0] OP_MVRJAC = 8'd9;
    localparam logic [7:0] OP_MVRKAC = 8'd10;
    localparam logic [7:0] OP_MVACRL = 8'd11;
    localparam logic [7:0] OP_MVRLAC = 8'd12;
    localparam logic [7:0] OP_STACI  = 8'd13;
    localparam logic [7:0] OP_ADD    = 8'd14;
    localparam logic [7:0] OP_SUB    = 8'd15;
    localparam logic [7:0] OP_MUL    = 8'd16;
    localparam logic [7:0] OP_INCRI  = 8'd17;
    localparam logic [7:0] OP_INCRJ  = 8'd18;
    localparam logic [7:0] OP_INCRK  = 8'd19;
    localparam logic [7:0] OP_INCRL  = 8'd20;
    localparam logic [7:0] OP_DECRI  = 8'd21;
    localparam logic [7:0] OP_DECRJ  = 8'd22;
    localparam logic [7:0] OP_DECRK  = 8'd23;
    localparam logic [7:0] OP_CLAC   = 8'd24;
    localparam logic [7:0] OP_RSTALL = 8'd25;
    localparam logic [7:0] OP_INAC   = 8'd26;
    localparam logic [7:0] OP_JPNZ   = 8'd27;
    localparam logic [7:0] OP_ENDOP  = 8'd28;
    localparam logic [7:0] OP_MVACRA = 8'd29;
    localparam logic [7:0] OP_MVRAAC = 8'd30;
    localparam logic [7:0] OP_MVACRB = 8'd31;
    localparam logic [7:0] OP_MVRBAC = 8'd32;
    localparam logic [7:0] OP_MVACRC = 8'd33;
    localparam logic [7:0] OP_MVRCAC = 8'd34;
    localparam logic [7:0] OP_LDIA   = 8'd35;
    localparam logic [7:0] OP_LDIB   = 8'd36;
    localparam logic [7:0] OP_STIC   = 8'd37;
    localparam logic [7:0] OP_ACCMUL = 8'd38;
    localparam logic [7:0] OP_CLRC   = 8'd39;
    localparam logic [7:0] OP_NOP    = 8'd40;

    localparam logic [7:0] OP_LAST   = OP_NOP;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_OP,
        ST_LAT_OP,
        ST_RD_ARG,
        ST_LAT_ARG,
        ST_ISSUE,
        ST_HALT
    } fetch_state_t;

    function automatic logic has_operand(input logic [7:0] op);
        return (op == OP_LDACI) || (op == OP_STACI) || (op == OP_JPNZ);
    endfunction

endpackage

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: owns the PC, reads 1/2-byte instructions from a
// synchronous byte memory, and gates host program loads to idle/halt.
module instr_fetch_ctrl
    import instr_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ADDR_WIDTH-1:0]   start_pc,
    input  logic                    load_valid,
    input  logic [ADDR_WIDTH-1:0]   load_addr,
    input  logic [2*DATA_WIDTH-1:0] load_data,
    output logic                    load_ready,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_w_addr,
    output logic [2*DATA_WIDTH-1:0] mem_w_instr,
    output logic [ADDR_WIDTH-1:0]   mem_r_addr,
    input  logic [DATA_WIDTH-1:0]   mem_r_instr,
    output logic                    instr_valid,
    input  logic                    instr_ready,
    output logic [DATA_WIDTH-1:0]   opcode,
    output logic [DATA_WIDTH-1:0]   operand,
    input  logic                    jump_taken,
    output logic [ADDR_WIDTH-1:0]   pc,
    output logic                    busy,
    output logic                    halted,
    output logic                    illegal
);

    fetch_state_t            r_state;
    logic [ADDR_WIDTH-1:0]   r_pc;
    logic [DATA_WIDTH-1:0]   r_opcode;
    logic [DATA_WIDTH-1:0]   r_operand;
    logic                    r_halted;
    logic                    r_illegal;

    logic                    w_idle;
    logic                    w_two_byte;
    logic                    w_jump;
    logic [ADDR_WIDTH-1:0]   w_pc_seq;
    logic [ADDR_WIDTH-1:0]   w_pc_next;
    logic                    w_op_illegal;
    logic                    w_op_has_arg;

    assign w_idle       = (r_state == ST_IDLE) || (r_state == ST_HALT);
    assign w_two_byte   = has_operand(r_opcode[7:0]);
    assign w_jump       = (r_opcode == DATA_WIDTH'(OP_JPNZ)) && jump_taken;
    assign w_pc_seq     = r_pc + (w_two_byte ? ADDR_WIDTH'(2)
                                             : ADDR_WIDTH'(1));
    assign w_pc_next    = w_jump ? ADDR_WIDTH'(r_operand) : w_pc_seq;
    assign w_op_illegal = mem_r_instr > DATA_WIDTH'(OP_LAST);
    assign w_op_has_arg = has_operand(mem_r_instr[7:0]);

    // Host writes only reach memory while no fetch is in flight.
    assign load_ready   = w_idle;
    assign mem_we       = w_idle & load_valid;
    assign mem_w_addr   = load_addr;
    assign mem_w_instr  = load_data;

    assign mem_r_addr   = (r_state == ST_RD_ARG) ? r_pc + ADDR_WIDTH'(1)
                                                 : r_pc;

    assign instr_valid  = (r_state == ST_ISSUE);
    assign busy         = !w_idle;
    assign opcode       = r_opcode;
    assign operand      = r_operand;
    assign pc           = r_pc;
    assign halted       = r_halted;
    assign illegal      = r_illegal;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_pc      <= '0;
            r_opcode  <= '0;
            r_operand <= '0;
            r_halted  <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE, ST_HALT: begin
                    if (start) begin
                        r_state   <= ST_RD_OP;
                        r_pc      <= start_pc;
                        r_halted  <= 1'b0;
                        r_illegal <= 1'b0;
                    end
                end
                ST_RD_OP: begin
                    r_state <= ST_LAT_OP;
                end
                ST_LAT_OP: begin
                    r_opcode <= mem_r_instr;
                    if (w_op_illegal) begin
                        r_state   <= ST_HALT;
                        r_halted  <= 1'b1;
                        r_illegal <= 1'b1;
                    end else if (w_op_has_arg) begin
                        r_state <= ST_RD_ARG;
                    end else begin
                        r_operand <= '0;
                        r_state   <= ST_ISSUE;
                    end
                end
                ST_RD_ARG: begin
                    r_state <= ST_LAT_ARG;
                end
                ST_LAT_ARG: begin
                    r_operand <= mem_r_instr;
                    r_state   <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (instr_ready) begin
                        // ENDOP keeps pc on itself so the host sees where it stopped.
                        if (r_opcode == DATA_WIDTH'(OP_ENDOP)) begin
                            r_state  <= ST_HALT;
                            r_halted <= 1'b1;
                        end else begin
                            r_pc    <= w_pc_next;
                            r_state <= ST_RD_OP;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
